anim_sequencer: RTL and testbench
=================================

ANIM_SEQUENCER -- requirements
Module: anim_sequencer

Interface
REQ-001 Parameter TICKS_PER_AFRAME, default 4: frame_tick pulses per animation frame, legal range 1..15.
REQ-002 Parameter ATK1_FRAMES, default 6: atk1 length in animation frames, legal range 2..63.
REQ-003 Parameter ATK2_FRAMES, default 8: atk2 length in animation frames, legal range 2..63.
REQ-004 Parameter ATK1_ACT_LO / ATK1_ACT_HI, default 2/3: atk1 hitbox-active frame window, inclusive.
REQ-005 Parameter ATK2_ACT_LO / ATK2_ACT_HI, default 3/5: atk2 hitbox-active frame window, inclusive.
REQ-006 Parameter JUMP_FRAMES, default 16, and HIT_FRAMES, default 12: jump and hitstun lengths, legal range 1..63.
REQ-007 Port clk, input, 1: single system clock; all state changes on its rising edge.
REQ-008 Port rst, input, 1: asynchronous, active-high reset.
REQ-009 Port frame_tick, input, 1: one-cycle pulse per video frame.
REQ-010 Ports move_left and move_right, input, 1 each: level inputs.
REQ-011 Ports jump_req, atk1_req, atk2_req, input, 1 each: level requests.
REQ-012 Ports hit_evt and lose_evt, input, 1 each: one-cycle event pulses.
REQ-013 Port anim_state, output, 4: 0 idle, 1 walk, 2 jump, 3 atk1, 4 atk2, 5 hit, 6 lose; codes 7..15 never driven.
REQ-014 Port anim_frame, output, 6: frame index within the current state.
REQ-015 Port atk_active, output, 1: hitbox live.
REQ-016 Port busy, output, 1: high in jump/atk1/atk2/hit/lose.
REQ-017 Port anim_done, output, 1: one-cycle pulse when a timed state completes.

Function
REQ-018 All outputs SHALL be registered or decoded only from registered state; no combinational path from any input to any output.
REQ-019 Sub-counter SHALL advance only on frame_tick; on the frame_tick where it equals TICKS_PER_AFRAME-1 it wraps to 0 and anim_frame increments.
REQ-020 Every state entry, including re-entry of hit, SHALL clear anim_frame and the sub-counter in the same edge that updates anim_state.
REQ-021 Idle, walk and lose SHALL hold anim_frame at 0.
REQ-022 Transitions, highest priority first: lose_evt -> lose from any state; hit_evt -> hit from any state except lose; then the from-idle/walk rules below.
REQ-023 From idle/walk: atk2_req -> atk2, else atk1_req -> atk1, else jump_req -> jump.
REQ-024 Otherwise from idle/walk: move_left XOR move_right -> walk; else idle.
REQ-025 Jump, atk1, atk2 and hit SHALL ignore move/jump/atk requests.
REQ-026 A timed state SHALL exit to idle on the wrap edge where anim_frame = N-1 (N = that state's frame parameter).
REQ-027 On that exit edge, anim_done SHALL pulse for one cycle, coincident with anim_state = idle.
REQ-028 Lose SHALL be sticky until rst.
REQ-029 hit_evt and lose_evt in the same cycle SHALL give lose.
REQ-030 hit_evt on a completion edge SHALL give hit, with no anim_done pulse.
REQ-031 atk_active SHALL be 1 only when anim_state = atk1/atk2 and anim_frame is within the matching ACT window.
REQ-032 Requests SHALL be sampled each clk; a request held through an attack SHALL start a new attack the cycle after idle is entered.

Reset
REQ-033 rst SHALL immediately force anim_state = 0, anim_frame = 0, sub-counter = 0, atk_active = 0, busy = 0, anim_done = 0.
REQ-034 rst asserted mid-animation SHALL abandon it, with no anim_done pulse.
REQ-035 After rst deasserts, the first transition SHALL occur on the following clk edge.

Structure
REQ-036 State codes 0..6 and the anim_frame width (6) SHALL live in shared package fighter_anim_pkg, also used by the sprite mapping logic.
REQ-037 The sub-counter SHALL be one sub-module, anim_tick_div (inputs clk, rst, frame_tick, clear; output afr_step).
REQ-038 Parameter range checks SHALL be elaboration-time assertions.

Verification
REQ-039 rst pulse mid-atk2 (frame 4) -> all outputs 0 immediately; no anim_done pulse.
REQ-040 Defaults, idle, atk1_req one cycle, frame_tick every 10 clk -> anim_frame 0..5, each held 4 ticks; atk_active high exactly during frames 2-3; idle plus anim_done on the 24th tick.
REQ-041 atk1_req and atk2_req together from walk -> anim_state = 4; busy = 1 the next cycle.
REQ-042 hit_evt at atk2 frame 4 -> anim_state = 5, anim_frame = 0, atk_active = 0; idle after 48 ticks.
REQ-043 hit_evt and lose_evt same cycle -> anim_state = 6; later hit_evt and atk1_req ignored.
REQ-044 move_left and move_right both high in idle -> stays idle; move_right alone -> walk, anim_frame = 0.

Source files
------------

// File: rtl/fighter_anim_pkg.sv
// Shared fighter animation codes and frame-index width, also used by sprite mapping.
// Pure declarations: no timing or flow-control behaviour.
package fighter_anim_pkg;

   localparam int FRAME_W = 6;

   typedef enum logic [3:0] {
      ST_IDLE = 4'd0,
      ST_WALK = 4'd1,
      ST_JUMP = 4'd2,
      ST_ATK1 = 4'd3,
      ST_ATK2 = 4'd4,
      ST_HIT  = 4'd5,
      ST_LOSE = 4'd6
   } anim_state_e;

   // Timed states run off the frame counter and return to idle when it expires.
   function automatic logic is_timed(input anim_state_e s);
      return (s == ST_JUMP) || (s == ST_ATK1) || (s == ST_ATK2) || (s == ST_HIT);
   endfunction

   function automatic logic is_busy(input anim_state_e s);
      return is_timed(s) || (s == ST_LOSE);
   endfunction

endpackage

// File: rtl/anim_tick_div.sv
// Divides frame_tick down to one afr_step per animation frame; clear restarts the count.
// Step is combinational from the registered count and frame_tick; no backpressure.
module anim_tick_div #(
   parameter int TICKS = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic frame_tick,
   input  logic clear,
   output logic afr_step
);

   logic [3:0] sub;

   assign afr_step = frame_tick && (sub == 4'(TICKS - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sub <= 4'd0;
      end else if (clear) begin
         sub <= 4'd0;
      end else if (frame_tick) begin
         sub <= afr_step ? 4'd0 : sub + 4'd1;
      end
   end

endmodule

// File: rtl/anim_sequencer.sv
// Fighter animation state machine: picks the animation, steps its frame index, flags hitbox/busy/done.
// All outputs registered; requests take effect on the next clk edge, no backpressure.
module anim_sequencer
   import fighter_anim_pkg::*;
#(
   parameter int TICKS_PER_AFRAME = 4,
   parameter int ATK1_FRAMES      = 6,
   parameter int ATK2_FRAMES      = 8,
   parameter int ATK1_ACT_LO      = 2,
   parameter int ATK1_ACT_HI      = 3,
   parameter int ATK2_ACT_LO      = 3,
   parameter int ATK2_ACT_HI      = 5,
   parameter int JUMP_FRAMES      = 16,
   parameter int HIT_FRAMES       = 12
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               frame_tick,
   input  logic               move_left,
   input  logic               move_right,
   input  logic               jump_req,
   input  logic               atk1_req,
   input  logic               atk2_req,
   input  logic               hit_evt,
   input  logic               lose_evt,
   output logic [3:0]         anim_state,
   output logic [FRAME_W-1:0] anim_frame,
   output logic               atk_active,
   output logic               busy,
   output logic               anim_done
);

   if (TICKS_PER_AFRAME < 1 || TICKS_PER_AFRAME > 15) begin : g_bad_tpf
      $error("TICKS_PER_AFRAME out of range 1..15");
   end
   if (ATK1_FRAMES < 2 || ATK1_FRAMES > 63 || ATK2_FRAMES < 2 || ATK2_FRAMES > 63) begin : g_bad_atk
      $error("ATK1_FRAMES/ATK2_FRAMES out of range 2..63");
   end
   if (JUMP_FRAMES < 1 || JUMP_FRAMES > 63 || HIT_FRAMES < 1 || HIT_FRAMES > 63) begin : g_bad_jh
      $error("JUMP_FRAMES/HIT_FRAMES out of range 1..63");
   end
   if (ATK1_ACT_LO > ATK1_ACT_HI || ATK1_ACT_HI >= ATK1_FRAMES ||
       ATK2_ACT_LO > ATK2_ACT_HI || ATK2_ACT_HI >= ATK2_FRAMES) begin : g_bad_act
      $error("attack active window outside its animation");
   end

   anim_state_e        state, nxt_state;
   logic [FRAME_W-1:0] frame, nxt_frame;
   logic               enter, done_nxt, act_nxt, step, clear;

   function automatic logic [FRAME_W-1:0] last_frame(input anim_state_e s);
      case (s)
         ST_JUMP: return FRAME_W'(JUMP_FRAMES - 1);
         ST_ATK1: return FRAME_W'(ATK1_FRAMES - 1);
         ST_ATK2: return FRAME_W'(ATK2_FRAMES - 1);
         ST_HIT:  return FRAME_W'(HIT_FRAMES - 1);
         default: return '0;
      endcase
   endfunction

   // Outside timed states the divider is held at zero so every entry starts a fresh frame.
   assign clear = enter || !is_timed(state);

   anim_tick_div #(.TICKS(TICKS_PER_AFRAME)) u_div (
      .clk        (clk),
      .rst        (rst),
      .frame_tick (frame_tick),
      .clear      (clear),
      .afr_step   (step)
   );

   always_comb begin
      nxt_state = state;
      nxt_frame = frame;
      enter     = 1'b0;
      done_nxt  = 1'b0;
      if (state == ST_LOSE) begin
         nxt_state = ST_LOSE;
      end else if (lose_evt) begin
         nxt_state = ST_LOSE;
         enter     = 1'b1;
      end else if (hit_evt) begin
         nxt_state = ST_HIT;
         enter     = 1'b1;
      end else if (!is_timed(state)) begin
         if (atk2_req)                    nxt_state = ST_ATK2;
         else if (atk1_req)               nxt_state = ST_ATK1;
         else if (jump_req)               nxt_state = ST_JUMP;
         else if (move_left ^ move_right) nxt_state = ST_WALK;
         else                             nxt_state = ST_IDLE;
         enter = (nxt_state != state);
      end else if (step) begin
         if (frame == last_frame(state)) begin
            nxt_state = ST_IDLE;
            enter     = 1'b1;
            done_nxt  = 1'b1;
         end else begin
            nxt_frame = frame + 6'd1;
         end
      end
      if (enter) nxt_frame = '0;

      act_nxt = ((nxt_state == ST_ATK1) &&
                 (nxt_frame >= FRAME_W'(ATK1_ACT_LO)) && (nxt_frame <= FRAME_W'(ATK1_ACT_HI))) ||
                ((nxt_state == ST_ATK2) &&
                 (nxt_frame >= FRAME_W'(ATK2_ACT_LO)) && (nxt_frame <= FRAME_W'(ATK2_ACT_HI)));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         frame      <= '0;
         atk_active <= 1'b0;
         busy       <= 1'b0;
         anim_done  <= 1'b0;
      end else begin
         state      <= nxt_state;
         frame      <= nxt_frame;
         atk_active <= act_nxt;
         busy       <= is_busy(nxt_state);
         anim_done  <= done_nxt;
      end
   end

   assign anim_state = state;
   assign anim_frame = frame;

endmodule

// File: tb/tb_anim_sequencer.sv
// Self-checking bench for anim_sequencer: directed scenarios plus random stimulus against a tick-count model.
module tb_anim_sequencer;

   localparam int TPF = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       frame_tick, move_left, move_right, jump_req, atk1_req, atk2_req, hit_evt, lose_evt;
   logic [3:0] anim_state;
   logic [5:0] anim_frame;
   logic       atk_active, busy, anim_done;

   int errors = 0;
   int checks = 0;

   // Model: state code plus frame_ticks seen since entering it.
   int m_state = 0;
   int m_ticks = 0;
   int m_done  = 0;

   always #5 clk = ~clk;

   anim_sequencer dut (
      .clk        (clk),
      .rst        (rst),
      .frame_tick (frame_tick),
      .move_left  (move_left),
      .move_right (move_right),
      .jump_req   (jump_req),
      .atk1_req   (atk1_req),
      .atk2_req   (atk2_req),
      .hit_evt    (hit_evt),
      .lose_evt   (lose_evt),
      .anim_state (anim_state),
      .anim_frame (anim_frame),
      .atk_active (atk_active),
      .busy       (busy),
      .anim_done  (anim_done)
   );

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int len_of(input int s);
      case (s)
         2: return 16;
         3: return 6;
         4: return 8;
         5: return 12;
         default: return 0;
      endcase
   endfunction

   function automatic int m_frame();
      return (m_state >= 2 && m_state <= 5) ? m_ticks / TPF : 0;
   endfunction

   function automatic int m_active();
      int f;
      f = m_frame();
      return ((m_state == 3 && f >= 2 && f <= 3) || (m_state == 4 && f >= 3 && f <= 5)) ? 1 : 0;
   endfunction

   task automatic model_step();
      m_done = 0;
      if (rst) begin
         m_state = 0; m_ticks = 0;
      end else if (m_state == 6) begin
         m_state = 6;
      end else if (lose_evt) begin
         m_state = 6; m_ticks = 0;
      end else if (hit_evt) begin
         m_state = 5; m_ticks = 0;
      end else if (m_state <= 1) begin
         m_ticks = 0;
         if (atk2_req)                    m_state = 4;
         else if (atk1_req)               m_state = 3;
         else if (jump_req)               m_state = 2;
         else if (move_left != move_right) m_state = 1;
         else                             m_state = 0;
      end else if (frame_tick) begin
         m_ticks++;
         if (m_ticks == len_of(m_state) * TPF) begin
            m_state = 0; m_ticks = 0; m_done = 1;
         end
      end
   endtask

   task automatic compare_all();
      check("state",  anim_state, m_state);
      check("frame",  anim_frame, m_frame());
      check("active", atk_active, m_active());
      check("busy",   busy,       (m_state >= 2) ? 1 : 0);
      check("done",   anim_done,  m_done);
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic clr_in();
      frame_tick = 0; move_left = 0; move_right = 0; jump_req = 0;
      atk1_req = 0; atk2_req = 0; hit_evt = 0; lose_evt = 0;
   endtask

   task automatic do_reset();
      rst = 1; clr_in();
      cyc();
      rst = 0;
   endtask

   initial begin
      clr_in();
      do_reset();
      check("rst_state", anim_state, 0);

      // atk1 with a frame_tick every 10 clocks
      atk1_req = 1; cyc(); atk1_req = 0;
      check("a1_enter", anim_state, 3);
      for (int t = 1; t <= 24; t++) begin
         repeat (9) cyc();
         frame_tick = 1; cyc(); frame_tick = 0;
         if (t < 24) begin
            check("a1_frame", anim_frame, t / TPF);
            check("a1_act", atk_active, (t / TPF >= 2 && t / TPF <= 3) ? 1 : 0);
         end else begin
            check("a1_end_state", anim_state, 0);
            check("a1_end_done", anim_done, 1);
         end
      end
      cyc();
      check("a1_done_pulse", anim_done, 0);

      // opposing moves cancel, single move walks
      do_reset();
      move_left = 1; move_right = 1; cyc();
      check("both_move", anim_state, 0);
      move_left = 0; cyc();
      check("walk_state", anim_state, 1);
      check("walk_frame", anim_frame, 0);

      // both attacks from walk: atk2 wins
      atk1_req = 1; atk2_req = 1; cyc();
      atk1_req = 0; atk2_req = 0; move_right = 0;
      check("atk_prio", anim_state, 4);
      cyc();
      check("atk2_busy", busy, 1);

      // hit at atk2 frame 4, then full hitstun
      frame_tick = 1; repeat (16) cyc(); frame_tick = 0;
      check("a2_frame4", anim_frame, 4);
      hit_evt = 1; cyc(); hit_evt = 0;
      check("hit_state", anim_state, 5);
      check("hit_frame", anim_frame, 0);
      check("hit_act", atk_active, 0);
      frame_tick = 1; repeat (47) cyc();
      check("hit_still", anim_state, 5);
      cyc(); frame_tick = 0;
      check("hit_exit", anim_state, 0);
      check("hit_done", anim_done, 1);

      // asynchronous reset mid-atk2
      atk2_req = 1; cyc(); atk2_req = 0;
      frame_tick = 1; repeat (16) cyc(); frame_tick = 0;
      check("a2_pre_rst", anim_frame, 4);
      #2 rst = 1;
      #1;
      check("arst_state",  anim_state, 0);
      check("arst_frame",  anim_frame, 0);
      check("arst_active", atk_active, 0);
      check("arst_busy",   busy, 0);
      check("arst_done",   anim_done, 0);
      m_state = 0; m_ticks = 0; m_done = 0;
      rst = 0;
      cyc();
      check("post_rst_done", anim_done, 0);

      // hit and lose together, lose is sticky
      hit_evt = 1; lose_evt = 1; cyc(); lose_evt = 0;
      check("lose_prio", anim_state, 6);
      atk1_req = 1; cyc(); clr_in();
      check("lose_sticky", anim_state, 6);

      // random stimulus
      for (int i = 0; i < 4000; i++) begin
         rst        = ($urandom_range(0, 199) == 0);
         frame_tick = ($urandom_range(0, 2) == 0);
         move_left  = $urandom_range(0, 1) == 1;
         move_right = $urandom_range(0, 1) == 1;
         jump_req   = ($urandom_range(0, 15) == 0);
         atk1_req   = ($urandom_range(0, 15) == 0);
         atk2_req   = ($urandom_range(0, 15) == 0);
         hit_evt    = ($urandom_range(0, 49) == 0);
         lose_evt   = ($urandom_range(0, 399) == 0);
         cyc();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
